// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm link: decoder state encoding, default symbol
// timing and a counter-width helper.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } pwm_state_e;

  localparam int unsigned T_BIT_DEF  = 16;
  localparam int unsigned THRESH_DEF = 8;
  localparam int unsigned T_ONE      = 12;
  localparam int unsigned T_ZERO     = 4;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/pwm_decoder_if.sv
// Consumer-facing bundle of the pwm decoder: serial line in, decoded word and
// status pulses out.
interface pwm_decoder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              pwm_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              err;
  logic              busy;

  modport master (input pwm_in, output data_out, valid, err, busy);
  modport slave  (output pwm_in, input data_out, valid, err, busy);
endinterface

// File: rtl/pwm_sync_edge.sv
// SYNC_N-flop synchronizer for an asynchronous line followed by registered
// rise/fall pulses aligned with the registered level.
module pwm_sync_edge #(
  parameter int unsigned SYNC_N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_N-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], din};
      level  <= sync_q[SYNC_N-1];
      rise   <= sync_q[SYNC_N-1] & ~level;
      fall   <= ~sync_q[SYNC_N-1] & level;
    end
  end
endmodule

// File: rtl/pwm_decoder.sv
// Receive side of the pwm link: measures high widths on the synchronized line
// and assembles MSB-first words, flagging glitches, stuck-high and timeouts.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned T_BIT   = T_BIT_DEF,
  parameter int unsigned THRESH  = THRESH_DEF,
  parameter int unsigned MIN_HI  = 2,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned SYNC_N  = 2
) (
  input logic           clk,
  input logic           rst,
  pwm_decoder_if.master bus
);
  localparam int unsigned CW = cnt_width(T_BIT, TIMEOUT);
  localparam int unsigned BW = $clog2(DATA_W + 1);

  logic line_level, line_rise, line_fall;

  pwm_sync_edge #(.SYNC_N(SYNC_N)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.pwm_in),
    .level (line_level),
    .rise  (line_rise),
    .fall  (line_fall)
  );

  pwm_state_e        state_q, state_n;
  logic [CW-1:0]     hi_q, hi_n, lo_q, lo_n;
  logic [BW-1:0]     bit_q, bit_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic              err_n;

  logic [DATA_W-1:0] data_q;
  logic              valid_q, err_q, busy_q;

  always_comb begin
    state_n = state_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    err_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_rise) begin
          state_n = ST_HIGH;
          hi_n    = CW'(1);
        end
      end
      ST_HIGH: begin
        if (line_fall) begin
          if (hi_q < CW'(MIN_HI)) begin
            // A runt pulse before any bit is idle-line noise; inside a frame it aborts.
            state_n = ST_IDLE;
            err_n   = (bit_q != '0);
          end else begin
            shreg_n = {shreg_q[DATA_W-2:0], (hi_q >= CW'(THRESH))};
            bit_n   = bit_q + BW'(1);
            lo_n    = '0;
            state_n = (bit_q == BW'(DATA_W - 1)) ? ST_DONE : ST_LOW;
          end
        end else if (hi_q >= CW'(T_BIT - 1)) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else if (hi_q != '1) begin
          hi_n = hi_q + CW'(1);
        end
      end
      ST_LOW: begin
        if (line_rise) begin
          state_n = ST_HIGH;
          hi_n    = CW'(1);
        end else if (lo_q >= CW'(TIMEOUT - 1)) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else if (lo_q != '1) begin
          lo_n = lo_q + CW'(1);
        end
      end
      ST_DONE: begin
        // A rise here is the next frame's first edge; start it with a clean word.
        shreg_n = '0;
        bit_n   = '0;
        if (line_rise) begin
          state_n = ST_HIGH;
          hi_n    = CW'(1);
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n == ST_IDLE) begin
      hi_n    = '0;
      lo_n    = '0;
      bit_n   = '0;
      shreg_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      valid_q <= (state_q == ST_DONE);
      err_q   <= err_n;
      // busy ends together with the valid/err pulse, even if a new frame starts at once.
      busy_q  <= (state_q != ST_DONE) && (state_n != ST_IDLE);
      if (state_q == ST_DONE) begin
        data_q <= shreg_q;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;

  logic unused_level;
  assign unused_level = line_level;
endmodule
